// File: rtl/physical_block_control.sv
// Command-path control FSM for the SD-host physical layer: sequences the PTS/STP
// wrappers and the CMD pad, captures the response and hands it upstream.
module physical_block_control #(
  parameter int RESP_W = 38
) (
  input  logic              iClock_SD,
  input  logic              iReset,
  input  logic              iStrobe_in,
  input  logic              iTransmission_complete,
  input  logic              iReception_complete,
  input  logic              iNo_response,
  input  logic [RESP_W-1:0] iPad_response,
  input  logic              iAck_in,
  output logic              oReset_wrapper,
  output logic              oEnable_PTS_wrapper,
  output logic              oEnable_STP_wrapper,
  output logic              oPad_stable,
  output logic              oPad_enable,
  output logic              oLoad_send,
  output logic              oStrobe_out,
  output logic [RESP_W-1:0] oResponse,
  output logic              oAck_out
);

  typedef enum logic [2:0] {
    RESET     = 3'd0,
    IDLE      = 3'd1,
    LOAD      = 3'd2,
    SEND      = 3'd3,
    WAIT_RESP = 3'd4,
    STROBE    = 3'd5,
    WAIT_ACK  = 3'd6,
    ACK       = 3'd7
  } state_t;

  state_t state;

  // Output word order: reset_wrapper, en_pts, en_stp, pad_stable, pad_enable,
  // load_send, strobe_out, ack_out. Loaded together with the state so every
  // output is a flop that tracks the registered state exactly.
  logic [7:0] outs;

  function automatic logic [7:0] decode(input state_t s);
    logic [7:0] o;
    o = 8'h00;
    case (s)
      RESET:     o = 8'b1000_0000;
      LOAD:      o = 8'b0100_1100;
      SEND:      o = 8'b0101_1000;
      WAIT_RESP: o = 8'b0011_0000;
      STROBE:    o = 8'b0000_0010;
      ACK:       o = 8'b0000_0001;
      default:   o = 8'h00;
    endcase
    return o;
  endfunction

  always_ff @(posedge iClock_SD) begin
    if (!iReset) begin
      state     <= RESET;
      outs      <= decode(RESET);
      oResponse <= '0;
    end else begin
      case (state)
        RESET: begin
          state <= IDLE;
          outs  <= decode(IDLE);
        end
        IDLE: begin
          if (iStrobe_in) begin
            state <= LOAD;
            outs  <= decode(LOAD);
          end
        end
        LOAD: begin
          state <= SEND;
          outs  <= decode(SEND);
        end
        SEND: begin
          if (iTransmission_complete) begin
            state <= WAIT_RESP;
            outs  <= decode(WAIT_RESP);
          end
        end
        WAIT_RESP: begin
          // A real reception takes priority over a concurrent no-response flag.
          if (iReception_complete) begin
            state     <= STROBE;
            outs      <= decode(STROBE);
            oResponse <= iPad_response;
          end else if (iNo_response) begin
            state     <= STROBE;
            outs      <= decode(STROBE);
            oResponse <= '0;
          end
        end
        STROBE: begin
          state <= WAIT_ACK;
          outs  <= decode(WAIT_ACK);
        end
        WAIT_ACK: begin
          if (iAck_in) begin
            state <= ACK;
            outs  <= decode(ACK);
          end
        end
        ACK: begin
          state <= IDLE;
          outs  <= decode(IDLE);
        end
        default: begin
          state <= RESET;
          outs  <= decode(RESET);
        end
      endcase
    end
  end

  assign oReset_wrapper      = outs[7];
  assign oEnable_PTS_wrapper = outs[6];
  assign oEnable_STP_wrapper = outs[5];
  assign oPad_stable         = outs[4];
  assign oPad_enable         = outs[3];
  assign oLoad_send          = outs[2];
  assign oStrobe_out         = outs[1];
  assign oAck_out            = outs[0];

endmodule

// File: tb/tb_physical_block_control.sv
// Vector-table bench for physical_block_control with a response scoreboard
// popped on each oStrobe_out pulse.
module tb_physical_block_control;

  localparam int RESP_W = 38;

  localparam logic [7:0] O_RST  = 8'h80;
  localparam logic [7:0] O_IDLE = 8'h00;
  localparam logic [7:0] O_LOAD = 8'h4C;
  localparam logic [7:0] O_SEND = 8'h58;
  localparam logic [7:0] O_WRSP = 8'h30;
  localparam logic [7:0] O_STRB = 8'h02;
  localparam logic [7:0] O_WACK = 8'h00;
  localparam logic [7:0] O_ACK  = 8'h01;

  logic              clk = 1'b0;
  logic              rst_n, strobe_in, tx_done, rx_done, no_resp, ack_in;
  logic [RESP_W-1:0] pad_resp;
  logic              reset_wrapper, en_pts, en_stp, pad_stable, pad_enable;
  logic              load_send, strobe_out, ack_out;
  logic [RESP_W-1:0] response;
  logic [7:0]        outs;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic              rst_n, strobe, tc, rc, nr, ack;
    logic [RESP_W-1:0] pad;
    logic [7:0]        exp;
    logic              cap;
    logic              chk_resp;
    logic [RESP_W-1:0] resp;
    string             name;
  } vec_t;

  vec_t              vecs[$];
  logic [RESP_W-1:0] sb[$];

  physical_block_control #(.RESP_W(RESP_W)) dut (
    .iClock_SD             (clk),
    .iReset                (rst_n),
    .iStrobe_in            (strobe_in),
    .iTransmission_complete(tx_done),
    .iReception_complete   (rx_done),
    .iNo_response          (no_resp),
    .iPad_response         (pad_resp),
    .iAck_in               (ack_in),
    .oReset_wrapper        (reset_wrapper),
    .oEnable_PTS_wrapper   (en_pts),
    .oEnable_STP_wrapper   (en_stp),
    .oPad_stable           (pad_stable),
    .oPad_enable           (pad_enable),
    .oLoad_send            (load_send),
    .oStrobe_out           (strobe_out),
    .oResponse             (response),
    .oAck_out              (ack_out)
  );

  assign outs = {reset_wrapper, en_pts, en_stp, pad_stable, pad_enable,
                 load_send, strobe_out, ack_out};

  always #5 clk = ~clk;

  task automatic add(input string name, input logic r, input logic s, input logic tc,
                     input logic rc, input logic nr, input logic a,
                     input logic [RESP_W-1:0] pad, input logic [7:0] exp,
                     input logic cap, input logic chk, input logic [RESP_W-1:0] resp);
    vec_t v;
    v.name = name; v.rst_n = r; v.strobe = s; v.tc = tc; v.rc = rc; v.nr = nr; v.ack = a;
    v.pad = pad; v.exp = exp; v.cap = cap; v.chk_resp = chk; v.resp = resp;
    vecs.push_back(v);
  endtask

  task automatic run();
    vec_t v;
    logic [RESP_W-1:0] e;
    for (int i = 0; vecs.size() > 0; i++) begin
      v = vecs.pop_front();
      @(negedge clk);
      rst_n = v.rst_n; strobe_in = v.strobe; tx_done = v.tc; rx_done = v.rc;
      no_resp = v.nr; ack_in = v.ack; pad_resp = v.pad;
      if (v.cap) sb.push_back(v.resp);
      @(posedge clk);
      #1;
      checks++;
      if (outs !== v.exp) begin
        errors++;
        $display("FAIL %s outs: got %b want %b", v.name, outs, v.exp);
      end
      checks++;
      if (pad_enable === 1'b1 && en_stp === 1'b1) begin
        errors++;
        $display("FAIL %s pad_enable with stp enable: got 1/1 want not both", v.name);
      end
      if (v.chk_resp) begin
        checks++;
        if (response !== v.resp) begin
          errors++;
          $display("FAIL %s oResponse: got %h want %h", v.name, response, v.resp);
        end
      end
      if (strobe_out === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected strobe: got oResponse %h want no strobe", v.name, response);
        end else begin
          e = sb.pop_front();
          if (response !== e) begin
            errors++;
            $display("FAIL %s scoreboard response: got %h want %h", v.name, response, e);
          end
        end
      end
    end
  endtask

  localparam logic [RESP_W-1:0] Z    = '0;
  localparam logic [RESP_W-1:0] P_A  = 38'h2A_5A5A_5A5A;
  localparam logic [RESP_W-1:0] P_F  = 38'h3F_FFFF_FFFF;
  localparam logic [RESP_W-1:0] P_B  = 38'h12_3456_789A;
  localparam logic [RESP_W-1:0] P_H  = 38'h15_0000_00FF;

  initial begin
    rst_n = 1'b0; strobe_in = 1'b0; tx_done = 1'b0; rx_done = 1'b0;
    no_resp = 1'b0; ack_in = 1'b0; pad_resp = '0;

    // Reset and release.
    for (int k = 0; k < 3; k++) add("reset", 0,0,0,0,0,0, Z, O_RST, 0, 1, Z);
    add("release",      1,0,0,0,0,0, Z, O_IDLE, 0, 1, Z);
    add("idle_hold",    1,0,0,0,0,0, Z, O_IDLE, 0, 1, Z);
    add("idle_tc_ign",  1,0,1,0,0,0, Z, O_IDLE, 0, 1, Z);
    add("idle_ack_ign", 1,0,0,0,0,1, Z, O_IDLE, 0, 1, Z);
    // Normal transaction, with strobe/ack ignored during SEND.
    add("n_load",       1,1,0,0,0,0, Z, O_LOAD, 0, 0, Z);
    add("n_send1",      1,0,0,0,0,0, Z, O_SEND, 0, 0, Z);
    add("n_send_ign",   1,1,0,0,0,1, Z, O_SEND, 0, 0, Z);
    add("n_send3",      1,0,0,0,0,0, Z, O_SEND, 0, 0, Z);
    add("n_send4",      1,0,0,0,0,0, Z, O_SEND, 0, 0, Z);
    add("n_send5",      1,0,0,0,0,0, Z, O_SEND, 0, 0, Z);
    add("n_wresp",      1,0,1,0,0,0, Z, O_WRSP, 0, 0, Z);
    add("n_wresp_hold", 1,0,0,0,0,0, Z, O_WRSP, 0, 1, Z);
    add("n_strobe",     1,0,0,1,0,0, P_A, O_STRB, 1, 0, P_A);
    add("n_wack1",      1,0,0,0,0,0, Z, O_WACK, 0, 1, P_A);
    add("n_wack2",      1,0,0,0,0,0, Z, O_WACK, 0, 1, P_A);
    add("n_ack",        1,0,0,0,0,1, Z, O_ACK,  0, 1, P_A);
    add("n_idle",       1,0,0,0,0,0, Z, O_IDLE, 0, 1, P_A);
    // No response: pad garbage must not be captured.
    add("nr_load",      1,1,0,0,0,0, P_F, O_LOAD, 0, 0, Z);
    add("nr_send",      1,0,0,0,0,0, P_F, O_SEND, 0, 0, Z);
    add("nr_wresp",     1,0,1,0,0,0, P_F, O_WRSP, 0, 1, P_A);
    add("nr_strobe",    1,0,0,0,1,0, P_F, O_STRB, 1, 0, Z);
    add("nr_wack",      1,0,0,0,0,0, P_F, O_WACK, 0, 1, Z);
    add("nr_ack",       1,0,0,0,0,1, Z, O_ACK,  0, 1, Z);
    add("nr_idle",      1,0,0,0,0,0, Z, O_IDLE, 0, 1, Z);
    // Reception and no-response together: reception wins.
    add("both_load",    1,1,0,0,0,0, Z, O_LOAD, 0, 0, Z);
    add("both_send",    1,0,0,0,0,0, Z, O_SEND, 0, 0, Z);
    add("both_wresp",   1,0,1,0,0,0, Z, O_WRSP, 0, 0, Z);
    add("both_strobe",  1,0,0,1,1,0, P_B, O_STRB, 1, 0, P_B);
    add("both_wack",    1,0,0,0,0,0, Z, O_WACK, 0, 1, P_B);
    add("both_ack",     1,0,0,0,0,1, Z, O_ACK,  0, 1, P_B);
    add("both_idle",    1,0,0,0,0,0, Z, O_IDLE, 0, 1, P_B);
    run();

    // Reset asserted in the middle of SEND clears the response too.
    add("mr_load",      1,1,0,0,0,0, Z, O_LOAD, 0, 1, P_B);
    add("mr_send",      1,0,0,0,0,0, Z, O_SEND, 0, 1, P_B);
    add("mr_reset",     0,0,0,0,0,0, Z, O_RST,  0, 1, Z);
    add("mr_release",   1,0,0,0,0,0, Z, O_IDLE, 0, 1, Z);
    run();

    // Long wait for acknowledge: state and response must hold.
    add("ha_load",      1,1,0,0,0,0, Z, O_LOAD, 0, 0, Z);
    add("ha_send",      1,0,0,0,0,0, Z, O_SEND, 0, 0, Z);
    add("ha_wresp",     1,0,1,0,0,0, Z, O_WRSP, 0, 0, Z);
    add("ha_strobe",    1,0,0,1,0,0, P_H, O_STRB, 1, 0, P_H);
    for (int k = 0; k < 10; k++) add("ha_hold", 1,(k==4),(k==6),(k==2),0,0, P_F, O_WACK, 0, 1, P_H);
    add("ha_ack",       1,0,0,0,0,1, Z, O_ACK,  0, 1, P_H);
    add("ha_idle",      1,0,0,0,0,0, Z, O_IDLE, 0, 1, P_H);
    run();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
